// File: rtl/mac_seq_ctrl.sv
// Sequencer driving one registered MAC through a dot product per job, returning the result over valid/ready.
// Optional MAC_SEQ_RELU_EN: negative captured results are clamped to zero.
module mac_seq_ctrl #(
    parameter int N      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [N-1:0]      bias,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [N-1:0]      a_data,
    input  logic [N-1:0]      b_data,
    output logic              mac_ce,
    output logic [N-1:0]      mac_a,
    output logic [N-1:0]      mac_b,
    output logic [N-1:0]      mac_sum,
    input  logic [N-1:0]      mac_out,
    output logic [N-1:0]      res_data,
    output logic              res_valid,
    input  logic              res_ready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic                mac_ce_q;
    logic                first_q, first_d;
    logic [N-1:0]        res_data_q, res_data_d;
    logic                res_valid_q, res_valid_d;
    logic                job_load;

    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   base_a_q;
    logic [ADDR_W-1:0]   base_b_q;
    logic signed [N-1:0] bias_q;
    logic                zero_len_q;

    function automatic logic [N-1:0] capt_filter(input logic [N-1:0] v);
`ifdef MAC_SEQ_RELU_EN
        capt_filter = v[N-1] ? '0 : v;
`else
        capt_filter = v;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_en_d     = rd_en_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        first_d     = first_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        job_load    = 1'b0;

        // The first enabled MAC cycle of a job adds the bias; every later one feeds back mac_out.
        if (mac_ce_q) begin
            first_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    job_load = 1'b1;
                    first_d  = 1'b1;
                    idx_d    = '0;
                    if (len != '0) begin
                        state_d  = S_RUN;
                        rd_en_d  = 1'b1;
                        addr_a_d = base_a;
                        addr_b_d = base_b;
                    end else begin
                        state_d = S_CAPT;
                    end
                end
            end
            S_RUN: begin
                idx_d = idx_q + ONE;
                if (idx_q == len_q - ONE) begin
                    state_d = S_FLUSH;
                    rd_en_d = 1'b0;
                end else begin
                    addr_a_d = base_a_q + idx_d;
                    addr_b_d = base_b_q + idx_d;
                end
            end
            S_FLUSH: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                res_data_d  = capt_filter(zero_len_q ? $unsigned(bias_q) : mac_out);
                res_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rd_en_d     = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Stage boundary: control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rd_en_q     <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            mac_ce_q    <= 1'b0;
            first_q     <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_en_q     <= rd_en_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            mac_ce_q    <= rd_en_q;
            first_q     <= first_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (job_load) begin
            len_q      <= len;
            base_a_q   <= base_a;
            base_b_q   <= base_b;
            bias_q     <= $signed(bias);
            zero_len_q <= (len == '0);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rd_en     = rd_en_q;
    assign addr_a    = addr_a_q;
    assign addr_b    = addr_b_q;
    assign mac_ce    = mac_ce_q;
    assign mac_a     = a_data;
    assign mac_b     = b_data;
    assign mac_sum   = first_q ? $unsigned(bias_q) : mac_out;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: operand buffers and MAC modelled here, outputs checked every cycle
// against a job-level reference model plus hand-computed results.
module tb_mac_seq_ctrl;

    localparam int N  = 16;
    localparam int AW = 8;

`ifdef MAC_SEQ_RELU_EN
    localparam logic [N-1:0] EXP_NEG = 16'h0000;
`else
    localparam logic [N-1:0] EXP_NEG = 16'hFFA2;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] len       = '0;
    logic [N-1:0]  bias      = '0;
    logic [AW-1:0] base_a    = '0;
    logic [AW-1:0] base_b    = '0;
    logic          res_ready = 1'b0;
    logic [N-1:0]  a_data    = '0;
    logic [N-1:0]  b_data    = '0;
    logic [N-1:0]  mac_out   = '0;
    logic          busy, rd_en, mac_ce, res_valid;
    logic [AW-1:0] addr_a, addr_b;
    logic [N-1:0]  mac_a, mac_b, mac_sum, res_data;

    logic [N-1:0]  mem_a [256];
    logic [N-1:0]  mem_b [256];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rd_seen = 0;
    int ce_seen = 0;

    bit            m_active = 1'b0;
    int            m_s      = 0;
    int            m_len    = 0;
    logic [N-1:0]  m_bias   = '0;
    logic [N-1:0]  m_res    = '0;
    logic [AW-1:0] m_ba     = '0;
    logic [AW-1:0] m_bb     = '0;

    mac_seq_ctrl #(.N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
        .base_a(base_a), .base_b(base_b), .busy(busy), .rd_en(rd_en),
        .addr_a(addr_a), .addr_b(addr_b), .a_data(a_data), .b_data(b_data),
        .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_sum(mac_sum),
        .mac_out(mac_out), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[addr_a];
            b_data <= mem_b[addr_b];
        end
    end

    always @(posedge clk) begin
        if (mac_ce) mac_out <= mac_a * mac_b + mac_sum;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bias plus the first k products of the two address streams, modulo 2^N
    function automatic logic [N-1:0] dot_upto(input int k, input logic [AW-1:0] ba,
                                              input logic [AW-1:0] bb, input logic [N-1:0] b0);
        logic [N-1:0]  acc;
        logic [AW-1:0] ja, jb;
        acc = b0;
        for (int i = 0; i < k; i++) begin
            ja  = ba + AW'(i);
            jb  = bb + AW'(i);
            acc = acc + mem_a[ja] * mem_b[jb];
        end
        return acc;
    endfunction

    function automatic logic [N-1:0] model_relu(input logic [N-1:0] v);
`ifdef MAC_SEQ_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Reference model and per-cycle comparison
    initial begin
        int            d, k;
        logic          e_busy, e_rd, e_ce, e_vld;
        logic [AW-1:0] ea, eb;
        forever begin
            @(negedge clk);
            e_busy = 1'b0; e_rd = 1'b0; e_ce = 1'b0; e_vld = 1'b0; d = 0;
            if (!rst && m_active) begin
                d      = cyc - m_s;
                e_busy = (d >= 1);
                e_rd   = (d >= 1) && (d <= m_len);
                e_ce   = (d >= 2) && (d <= m_len + 1);
                e_vld  = (m_len == 0) ? (d >= 2) : (d >= m_len + 3);
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("mac_ce", 32'(mac_ce), 32'(e_ce));
            chk("res_valid", 32'(res_valid), 32'(e_vld));
            if (rd_en) rd_seen++;
            if (mac_ce) ce_seen++;
            if (rst) begin
                chk("rst_res_data", 32'(res_data), 32'(0));
                chk("rst_addr_a", 32'(addr_a), 32'(0));
                chk("rst_addr_b", 32'(addr_b), 32'(0));
            end
            if (e_rd) begin
                ea = m_ba + AW'(d - 1);
                eb = m_bb + AW'(d - 1);
                chk("addr_a", 32'(addr_a), 32'(ea));
                chk("addr_b", 32'(addr_b), 32'(eb));
            end
            if (e_ce) begin
                k  = d - 2;
                ea = m_ba + AW'(k);
                eb = m_bb + AW'(k);
                chk("mac_a", 32'(mac_a), 32'(mem_a[ea]));
                chk("mac_b", 32'(mac_b), 32'(mem_b[eb]));
                chk("mac_sum", 32'(mac_sum), 32'(dot_upto(k, m_ba, m_bb, m_bias)));
            end
            if (e_vld) chk("res_data", 32'(res_data), 32'(m_res));

            if (rst) begin
                m_active = 1'b0;
            end else if (m_active) begin
                if (e_vld && res_ready) m_active = 1'b0;
            end else if (start) begin
                m_active = 1'b1;
                m_s      = cyc;
                m_len    = int'(len);
                m_bias   = bias;
                m_ba     = base_a;
                m_bb     = base_b;
                m_res    = model_relu(dot_upto(int'(len), base_a, base_b, bias));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string tag, input int l, input logic [N-1:0] bi,
                           input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input int exp_lat, input logic [N-1:0] exp_res);
        int lat;
        len = AW'(l); bias = bi; base_a = ba; base_b = bb; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(res_data), 32'(exp_res));
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int r0, c0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_valid", 32'(res_valid), 32'(0));
        rst = 1'b0;
        tick();

        // len=3 basic dot product
        mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3;
        mem_b[0] = 16'd4; mem_b[1] = 16'd5; mem_b[2] = 16'd6;
        r0 = rd_seen; c0 = ce_seen;
        run_job("len3", 3, 16'd10, 8'h00, 8'h00, 6, 16'd42);
        accept();
        tick();
        chk("len3_rd_cycles", 32'(rd_seen - r0), 32'(3));
        chk("len3_ce_cycles", 32'(ce_seen - c0), 32'(3));

        // len=0 bias passthrough; start alongside res_ready in OUT must be ignored
        r0 = rd_seen; c0 = ce_seen;
        run_job("len0", 0, 16'd7, 8'h00, 8'h00, 2, 16'd7);
        res_ready = 1'b1; start = 1'b1; len = 8'd5;
        tick();
        res_ready = 1'b0; start = 1'b0;
        chk("len0_idle_after", 32'(busy), 32'(0));
        tick();
        chk("len0_still_idle", 32'(busy), 32'(0));
        chk("len0_rd_cycles", 32'(rd_seen - r0), 32'(0));
        chk("len0_ce_cycles", 32'(ce_seen - c0), 32'(0));

        // address wrap with backpressure and an ignored start during OUT
        mem_a[8'hFE] = 16'd300;  mem_a[8'hFF] = 16'hFFFE;
        mem_a[8'h00] = 16'd1000; mem_a[8'h01] = 16'd7;
        mem_b[8'h10] = 16'd200;  mem_b[8'h11] = 16'd50;
        mem_b[8'h12] = 16'd100;  mem_b[8'h13] = 16'hFFFD;
        run_job("wrap", 4, 16'd1, 8'hFE, 8'h10, 7, 16'd28808);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd2;
            tick();
            chk("bp_res_data", 32'(res_data), 32'(28808));
            chk("bp_busy", 32'(busy), 32'(1));
        end
        start = 1'b0;
        accept();
        chk("bp_released", 32'(busy), 32'(0));

        // fresh job accepted after the backpressured one
        mem_a[0] = 16'd2; mem_b[0] = 16'd3;
        run_job("bias5", 1, 16'd5, 8'h00, 8'h00, 4, 16'd11);
        accept();
        run_job("neg_bias", 1, 16'hFF9C, 8'h00, 8'h00, 4, EXP_NEG);
        accept();

        // reset in RUN at idx=2 of a len=8 job
        len = 8'd8; bias = 16'd0; base_a = 8'h40; base_b = 8'h50; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_rd_en", 32'(rd_en), 32'(0));
        chk("midrst_mac_ce", 32'(mac_ce), 32'(0));
        chk("midrst_valid", 32'(res_valid), 32'(0));
        tick();
        rst = 1'b0;
        mem_a[8'h20] = 16'd3; mem_b[8'h30] = 16'd3;
        run_job("post_rst", 1, 16'd0, 8'h20, 8'h30, 4, 16'd9);
        accept();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that drives one registered MAC unit through a dot product of length len: operand fetch from two synchronous-read buffers, MAC enable, and accumulator feedback.
- Sits between the layer scheduler (start/len/bias/base addresses) and the MAC datapath.
- Returns one N-bit result per job over a valid/ready handshake.

Parameters:
- N, 16, operand/result width (two's complement, integer mode)
- ADDR_W, 8, buffer address width; also the width of len

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job request pulse/level, sampled only in IDLE
- len  in  ADDR_W  number of taps (0..2^ADDR_W-1)
- bias  in  N  initial accumulator value
- base_a  in  ADDR_W  first address in operand-A buffer
- base_b  in  ADDR_W  first address in operand-B buffer
- busy  out  1  high whenever state != IDLE
- rd_en  out  1  buffer read strobe
- addr_a  out  ADDR_W  operand-A read address
- addr_b  out  ADDR_W  operand-B read address
- a_data  in  N  operand-A read data, valid the cycle after rd_en
- b_data  in  N  operand-B read data, valid the cycle after rd_en
- mac_ce  out  1  MAC clock enable
- mac_a  out  N  MAC multiplicand (combinational from a_data)
- mac_b  out  N  MAC multiplier (combinational from b_data)
- mac_sum  out  N  MAC addend
- mac_out  in  N  registered MAC output (data_out <= a*b+sum when ce)
- res_data  out  N  job result, held stable while res_valid
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result

Behaviour:
- States: IDLE, RUN, FLUSH, CAPT, OUT.
- Reset (async): state=IDLE, idx=0, all registered outputs 0 (busy, rd_en, addr_a, addr_b, mac_ce, res_data, res_valid). The MAC's own reset is not driven by this block.
- IDLE:
  - start=1, len!=0: latch len, bias, base_a, base_b; idx=0; go to RUN.
  - start=1, len==0: go to CAPT with the capture source = latched bias.
  - start=0: stay in IDLE.
- RUN: rd_en=1, addr_a=base_a+idx, addr_b=base_b+idx, both modulo 2^ADDR_W (wrap FF->00). idx increments each cycle. When idx==len-1, go to FLUSH. Lasts exactly len cycles.
- Operand path:
  - mac_ce = rd_en delayed one cycle.
  - mac_a=a_data, mac_b=b_data.
  - mac_sum = latched bias on the first mac_ce of the job, otherwise mac_out.
  - Result: consecutive MAC cycles chain correctly through the MAC's 1-cycle latency.
- FLUSH: one cycle; carries the final delayed mac_ce. Go to CAPT.
- CAPT: one cycle; res_data <= mac_out (or bias when len==0). Go to OUT.
- OUT: res_valid=1, res_data held. On res_ready=1, res_valid falls next cycle and state goes to IDLE.
- Latency: start sampled in cycle 0, len>0 -> res_valid first high in cycle len+3. len==0 -> cycle 2.
- start outside IDLE is ignored, including start and res_ready high together in OUT. The requester must hold or re-assert start once busy is low.
- Arithmetic: the MAC wraps modulo 2^N. The controller adds no saturation except the optional feature below.
- mac_ce is never asserted outside a job. mac_out is not sampled except in CAPT.
- Reset mid-job: immediate IDLE, rd_en and mac_ce low, no result produced. Partial MAC contents are don't-care.

Optional Feature:
- Macro MAC_SEQ_RELU_EN.
- Defined: in CAPT, if the captured value's bit N-1 is 1, res_data <= 0; otherwise the value passes unchanged. Applies to the len==0 bias path too.
- Undefined: res_data is the raw captured value. No extra logic, same latency either way.

Test Plan:
- len=3, bias=10, A[0..2]={1,2,3}, B[0..2]={4,5,6}, base_a=base_b=0 -> rd_en high cycles 1-3, mac_ce high cycles 2-4, res_data=42, res_valid first high in cycle 6.
- len=0, bias=7 -> no rd_en, no mac_ce, res_data=7 with res_valid high in cycle 2.
- Wrap: base_a=0xFE, base_b=0x10, len=4 -> addr_a FE,FF,00,01 and addr_b 10,11,12,13. Result equals the software dot product + bias modulo 2^16.
- Backpressure: res_ready low for 5 cycles after res_valid, with start pulsed during OUT -> res_data constant, busy=1, start ignored. One res_ready cycle returns the block to IDLE, and a new start is then accepted.
- Reset asserted in RUN at idx=2 of len=8 -> same cycle: busy, rd_en, mac_ce, res_valid all 0. A following job len=1, a=3, b=3, bias=0 yields 9.
- bias=0xFF9C (-100), len=1, a=2, b=3 -> 0xFFA2 without MAC_SEQ_RELU_EN, 0x0000 with it. bias=5 gives 11 in both builds.
